// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - two-byte instruction fetch sequencer with PC, redirect and decode handshake
//
// Purpose:
//   Pulls two consecutive bytes at pc from a byte-wide memory (address-load
//   strobe, then read strobe, data returned one cycle later), assembles a
//   16-bit instruction word and offers it to decode over ir_valid/ir_ready.
//   Execute-stage redirects (jump_en/jump_addr) abandon any fetch in flight.
//
// Configuration:
//   FETCH_LITTLE_ENDIAN_EN - when defined, the first fetched byte lands in
//   ir[7:0]; otherwise (default) it lands in ir[15:8].
//
// Ports:
//   clk          system clock, all state changes on posedge
//   rst          synchronous reset, active-low
//   mem_addr_en  memory address-register load strobe
//   mem_addr     address presented with mem_addr_en, held otherwise
//   mem_out_en   memory read strobe (data appears on mem_data next cycle)
//   mem_data     memory read data, only [7:0] used
//   ir_valid     ir holds a complete instruction
//   ir           fetched instruction word
//   ir_ready     decode accepts ir this cycle
//   jump_en      redirect request
//   jump_addr    redirect target byte address
//   pc           address of the next instruction to fetch

module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_addr_en,
    output logic [15:0] mem_addr,
    output logic        mem_out_en,
    input  logic [15:0] mem_data,
    output logic        ir_valid,
    output logic [15:0] ir,
    input  logic        ir_ready,
    input  logic        jump_en,
    input  logic [15:0] jump_addr,
    output logic [15:0] pc
);

    typedef enum logic [2:0] {
        S_ADDR0 = 3'd0,
        S_READ0 = 3'd1,
        S_CAP0  = 3'd2,
        S_READ1 = 3'd3,
        S_CAP1  = 3'd4,
        S_HOLD  = 3'd5
    } state_t;

    state_t      state_q;
    logic [15:0] pc_q;
    logic [15:0] ir_q;
    logic        ir_valid_q;
    logic [7:0]  hi_q;
    logic [15:0] mem_addr_q;

    logic [15:0] addr_d;
    logic [15:0] ir_d;
    logic        unused_mem_hi;

    assign unused_mem_hi = ^mem_data[15:8];

    // Strobes are decoded from state alone; the only input allowed to
    // influence them is reset, which silences the memory interface.
    assign mem_addr_en = rst && ((state_q == S_ADDR0) || (state_q == S_CAP0));
    assign mem_out_en  = rst && ((state_q == S_READ0) || (state_q == S_READ1));

    // Second byte address wraps naturally through 16-bit arithmetic.
    assign addr_d   = (state_q == S_CAP0) ? (pc_q + 16'd1) : pc_q;
    assign mem_addr = mem_addr_en ? addr_d : mem_addr_q;

`ifdef FETCH_LITTLE_ENDIAN_EN
    assign ir_d = {mem_data[7:0], hi_q};
`else
    assign ir_d = {hi_q, mem_data[7:0]};
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_ADDR0;
            pc_q       <= RESET_PC;
            ir_q       <= 16'h0000;
            ir_valid_q <= 1'b0;
            hi_q       <= 8'h00;
            mem_addr_q <= RESET_PC;
        end else begin
            if (mem_addr_en) begin
                mem_addr_q <= addr_d;
            end
            // A redirect wins over everything, including a handshake in the
            // same cycle (the held instruction is simply dropped as consumed)
            // and the final capture of a fetch that is now stale.
            if (jump_en) begin
                pc_q       <= jump_addr;
                ir_valid_q <= 1'b0;
                state_q    <= S_ADDR0;
            end else begin
                case (state_q)
                    S_ADDR0: state_q <= S_READ0;
                    S_READ0: state_q <= S_CAP0;
                    S_CAP0: begin
                        hi_q    <= mem_data[7:0];
                        state_q <= S_READ1;
                    end
                    S_READ1: state_q <= S_CAP1;
                    S_CAP1: begin
                        ir_q       <= ir_d;
                        ir_valid_q <= 1'b1;
                        pc_q       <= pc_q + 16'd2;
                        state_q    <= S_HOLD;
                    end
                    S_HOLD: begin
                        if (ir_ready) begin
                            ir_valid_q <= 1'b0;
                            state_q    <= S_ADDR0;
                        end
                    end
                    default: state_q <= S_ADDR0;
                endcase
            end
        end
    end

    assign ir_valid = ir_valid_q;
    assign ir       = ir_q;
    assign pc       = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit

module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_addr_en;
    logic [15:0] mem_addr;
    logic        mem_out_en;
    logic [15:0] mem_data = 16'h0000;
    logic        ir_valid;
    logic [15:0] ir;
    logic        ir_ready = 1'b0;
    logic        jump_en = 1'b0;
    logic [15:0] jump_addr = 16'h0000;
    logic [15:0] pc;

    int vectors = 0;
    int errors  = 0;
    bit armed   = 1'b0;

    logic [7:0] mem [0:255];
    logic [15:0] maddr = 16'h0000;

    fetch_unit #(.RESET_PC(16'h0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_addr_en(mem_addr_en),
        .mem_addr   (mem_addr),
        .mem_out_en (mem_out_en),
        .mem_data   (mem_data),
        .ir_valid   (ir_valid),
        .ir         (ir),
        .ir_ready   (ir_ready),
        .jump_en    (jump_en),
        .jump_addr  (jump_addr),
        .pc         (pc)
    );

    always #5 clk = ~clk;

    // Byte memory with an 8-bit address alias; upper data bits carry junk.
    always @(posedge clk) begin
        if (mem_addr_en) maddr <= mem_addr;
        if (mem_out_en)  mem_data <= {8'hA5, mem[maddr[7:0]]};
    end

    function automatic logic [15:0] word(input logic [7:0] first, input logic [7:0] second);
`ifdef FETCH_LITTLE_ENDIAN_EN
        return {second, first};
`else
        return {first, second};
`endif
    endfunction

    function automatic logic [7:0] byte_at(input logic [15:0] a);
        return mem[a[7:0]];
    endfunction

    // Model: a fetch is a timeline of cycles since it started. Cycles 0 and 2
    // load the address (pc, pc+1), 1 and 3 read, the instruction is complete
    // after cycle 4, and from cycle 5 it waits for decode.
    int          m_t = 0;
    logic [15:0] m_pc = 16'h0000;
    logic [15:0] m_ir = 16'h0000;
    logic        m_valid = 1'b0;
    logic [15:0] m_last = 16'h0000;
    logic        exp_en, exp_oe;
    logic [15:0] exp_addr;

    always_comb begin
        exp_en   = rst && (m_t == 0 || m_t == 2);
        exp_oe   = rst && (m_t == 1 || m_t == 3);
        exp_addr = exp_en ? (m_pc + 16'(m_t >> 1)) : m_last;
    end

    always @(posedge clk) begin
        if (!rst) begin
            m_t     <= 0;
            m_pc    <= 16'h0000;
            m_ir    <= 16'h0000;
            m_valid <= 1'b0;
            m_last  <= 16'h0000;
        end else begin
            if (exp_en) m_last <= exp_addr;
            if (jump_en) begin
                m_t     <= 0;
                m_pc    <= jump_addr;
                m_valid <= 1'b0;
            end else if (m_t == 5) begin
                if (ir_ready) begin
                    m_t     <= 0;
                    m_valid <= 1'b0;
                end
            end else begin
                m_t <= m_t + 1;
                if (m_t == 4) begin
                    m_ir    <= word(byte_at(m_pc), byte_at(m_pc + 16'd1));
                    m_valid <= 1'b1;
                    m_pc    <= m_pc + 16'd2;
                end
            end
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            check("cyc_ir_valid", 16'(ir_valid), 16'(m_valid));
            check("cyc_ir", ir, m_ir);
            check("cyc_pc", pc, m_pc);
            check("cyc_addr_en", 16'(mem_addr_en), 16'(exp_en));
            check("cyc_out_en", 16'(mem_out_en), 16'(exp_oe));
            check("cyc_addr", mem_addr, exp_addr);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    int last_xfer;
    int gap_checks;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
        mem[8'h00] = 8'h12;
        mem[8'h01] = 8'h34;
        mem[8'h40] = 8'h5A;
        mem[8'h41] = 8'hC3;
        mem[8'hFF] = 8'hAB;

        // Reset held with jump and ready asserted.
        rst = 1'b0; jump_en = 1'b1; jump_addr = 16'h1234; ir_ready = 1'b1;
        tick;
        armed = 1'b1;
        tick;
        tick;
        check("rst_valid", 16'(ir_valid), 16'h0000);
        check("rst_ir", ir, 16'h0000);
        check("rst_pc", pc, 16'h0000);
        check("rst_addr_en", 16'(mem_addr_en), 16'h0000);
        check("rst_out_en", 16'(mem_out_en), 16'h0000);

        rst = 1'b1; jump_en = 1'b0; ir_ready = 1'b0;
        #1;
        check("rel_addr_en", 16'(mem_addr_en), 16'h0001);
        check("rel_addr", mem_addr, 16'h0000);

        // Basic fetch, valid on the fifth edge.
        repeat (4) tick;
        check("lat_not_yet", 16'(ir_valid), 16'h0000);
        tick;
        check("basic_valid", 16'(ir_valid), 16'h0001);
        check("basic_ir", ir, word(8'h12, 8'h34));
        check("basic_pc", pc, 16'h0002);

        // Backpressure.
        repeat (10) tick;
        check("bp_ir", ir, word(8'h12, 8'h34));
        check("bp_valid", 16'(ir_valid), 16'h0001);
        check("bp_pc", pc, 16'h0002);
        check("bp_addr_en", 16'(mem_addr_en), 16'h0000);
        ir_ready = 1'b1;
        tick;
        ir_ready = 1'b0;
        check("hs_valid", 16'(ir_valid), 16'h0000);
        check("hs_addr_en", 16'(mem_addr_en), 16'h0001);
        check("hs_addr", mem_addr, 16'h0002);

        // Jump while waiting in the second read.
        repeat (3) tick;
        jump_en = 1'b1; jump_addr = 16'h0040;
        tick;
        jump_en = 1'b0;
        check("jmp_valid", 16'(ir_valid), 16'h0000);
        check("jmp_addr_en", 16'(mem_addr_en), 16'h0001);
        check("jmp_addr", mem_addr, 16'h0040);
        repeat (5) tick;
        check("jmp_ir", ir, word(8'h5A, 8'hC3));
        check("jmp_pc", pc, 16'h0042);

        // Wrap, jumping during a handshake.
        mem[8'h00] = 8'hCD;
        jump_en = 1'b1; jump_addr = 16'hFFFF; ir_ready = 1'b1;
        tick;
        jump_en = 1'b0; ir_ready = 1'b0;
        check("wrap_addr0", mem_addr, 16'hFFFF);
        check("wrap_pc0", pc, 16'hFFFF);
        repeat (2) tick;
        check("wrap_addr_en1", 16'(mem_addr_en), 16'h0001);
        check("wrap_addr1", mem_addr, 16'h0000);
        repeat (3) tick;
        check("wrap_ir", ir, word(8'hAB, 8'hCD));
        check("wrap_pc", pc, 16'h0001);

        // Reset in the hold state, then in the first capture.
        mem[8'h00] = 8'h12;
        rst = 1'b0;
        tick;
        check("rsthold_valid", 16'(ir_valid), 16'h0000);
        check("rsthold_pc", pc, 16'h0000);
        rst = 1'b1;
        repeat (2) tick;
        check("cap0_addr", mem_addr, 16'h0001);
        rst = 1'b0;
        tick;
        check("rstcap_pc", pc, 16'h0000);
        check("rstcap_addr_en", 16'(mem_addr_en), 16'h0000);
        rst = 1'b1;
        repeat (5) tick;
        check("restart_ir", ir, word(8'h12, 8'h34));
        check("restart_pc", pc, 16'h0002);

        // Back-to-back throughput with decode always ready.
        ir_ready = 1'b1;
        last_xfer = -1;
        gap_checks = 0;
        for (int c = 0; c < 40; c++) begin
            if (ir_valid) begin
                if (last_xfer >= 0) begin
                    check("throughput_gap", 16'(c - last_xfer), 16'd6);
                    gap_checks++;
                end
                last_xfer = c;
            end
            tick;
        end
        check("throughput_seen", 16'(gap_checks >= 5), 16'h0001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
